fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 14-bit ISA datapath; sits directly upstream of `memoria` (32 × 14-bit instruction/data memory). Holds the program counter, drives `memoria`'s address and enable pins, captures the 14-bit word returned on `data_out`, and presents it with its PC to the decode stage over a valid/ready handshake. Supports branch/jump redirect from downstream and an optional HALT stop.

## Interface
- `ADDR_W`, 5, PC / memory address width (32 words)
- `INSTR_W`, 14, instruction width
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, synchronous, active-low
- `mem_add`  out  ADDR_W  address to `memoria.add`
- `mem_en`  out  1  to `memoria.en`; constant 0 (read only, never writes)
- `mem_data_in`  out  INSTR_W  to `memoria.data_in`; constant 0
- `mem_data_out`  in  INSTR_W  from `memoria.data_out`; valid one cycle after `mem_add` is presented
- `instr_out`  out  INSTR_W  fetched instruction
- `instr_pc`  out  ADDR_W  address the instruction was fetched from
- `instr_valid`  out  1  `instr_out`/`instr_pc` valid
- `instr_ready`  in  1  decode accepts this cycle
- `br_taken`  in  1  redirect request, one-cycle pulse
- `br_target`  in  ADDR_W  redirect address
- `halted`  out  1  fetch stopped on HALT

## Operation
- FSM states: ISSUE, CAPTURE, PRESENT, HALTED.
- ISSUE: `mem_add`=pc; next state CAPTURE.
- CAPTURE: register `mem_data_out`→`instr_out`, pc→`instr_pc`; pc←pc+1 (mod 2^ADDR_W, 31 wraps to 0); `instr_valid`←1; next state PRESENT.
- PRESENT: outputs held stable while `instr_valid`=1 and `instr_ready`=0. On `instr_ready`=1: `instr_valid`←0; next state ISSUE (or HALTED, see Configuration).
- HALTED: no memory access, `halted`=1; exits only via `br_taken` or reset.
- `br_taken` in any state has top priority: pc←`br_target`, `instr_valid`←0, any in-flight or presented word discarded (even if `instr_ready`=1 the same cycle), `halted`←0, next state ISSUE.
- `mem_add` outside ISSUE holds the last issued address; `mem_en` always 0.

## Timing
- Reset (`rst_n`=0 at a rising edge): pc=RESET_PC, state=ISSUE, `instr_valid`=0, `instr_out`=0, `instr_pc`=0, `halted`=0, `mem_add`=RESET_PC.
- First edge with `rst_n`=1 leaves ISSUE; `instr_valid` is high 2 cycles after reset release.
- Latency ISSUE→`instr_valid`: 2 cycles. Throughput with `instr_ready` tied high: 1 instruction per 3 cycles.
- Redirect: `br_taken` at edge N → ISSUE of `br_target` in cycle N+1 → `instr_valid` for `br_target` at N+3.
- Reset mid-operation overrides everything, including a simultaneous `br_taken`.

## Configuration
- `FETCH_HALT_EN` defined: a captured word with `instr_out[13:10]`=4'hF is HALT; it is presented normally; once accepted, next state is HALTED and `halted`=1 from the following cycle. pc already points past the HALT.
- Not defined: no HALT decode; 4'hF words are ordinary instructions; `halted` tied 0; HALTED state unreachable.

## Structure
- `fetch_pkg`: `ADDR_W`/`INSTR_W` defaults, FSM state enum, `HALT_OPCODE`=4'hF, `HALT_MSB`=13/`HALT_LSB`=10.
- One sub-module `pc_counter`: synchronous active-low reset to RESET_PC, load (priority) and increment with wrap.

## Test plan
- Reset: hold `rst_n`=0 3 cycles → `instr_valid`=0, `halted`=0, `mem_add`=0, `mem_en`=0.
- Sequential fetch, memory preloaded word k = k+100, `instr_ready`=1 → outputs (pc 0,100),(1,101),(2,102), one every 3 cycles.
- Backpressure: `instr_ready`=0 for 5 cycles in PRESENT at pc 4 → `instr_out`=104, `instr_pc`=4 stable; no new ISSUE; resumes with pc 5 after ready.
- Wrap: `br_taken` to 30, ready=1 → instructions at 30, 31, 0, 1.
- Redirect collision: `br_taken` (target 9) same cycle as `instr_ready`=1 in PRESENT at pc 2 → pc-2 word dropped, next valid has `instr_pc`=9 three cycles later.
- With `FETCH_HALT_EN`, word 3 = 14'h3C00 → presented, accepted, `halted`=1, `mem_add` frozen; `br_taken` to 0 → `halted`=0, fetch restarts at 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// FSM state encoding and HALT opcode decode. The HALT feature itself is
// compiled in by the FETCH_HALT_EN macro inside fetch_unit.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 5;
  localparam int FETCH_INSTR_W = 14;

  // HALT is identified purely by the top opcode nibble of the word.
  localparam logic [3:0] HALT_OPCODE = 4'hF;
  localparam int         HALT_MSB    = 13;
  localparam int         HALT_LSB    = 10;

  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_PRESENT = 2'd2,
    ST_HALTED  = 2'd3
  } fetch_state_t;

  function automatic logic is_halt_opcode(input logic [3:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter register: synchronous active-low reset, load has
// priority over increment, increment wraps modulo 2^ADDR_W.
module pc_counter #(
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // PC update: reset, then redirect load, then sequential increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of the 32 x 14-bit memoria block.
// Cycle flow: ISSUE (address out) -> CAPTURE (read data back) ->
// PRESENT (valid/ready handshake to decode) -> ISSUE ...
// Handshake: instr_out/instr_pc are held stable while instr_valid=1 and
// instr_ready=0; a word transfers on a rising edge with both high, unless
// br_taken is high on that edge, in which case the word is discarded.
// Optional feature: define FETCH_HALT_EN to stop fetching after an
// accepted HALT word (opcode 4'hF); otherwise halted is tied low.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  mem_add,
  output logic               mem_en,
  output logic [INSTR_W-1:0] mem_data_in,
  input  logic [INSTR_W-1:0] mem_data_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               halted
);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic              pc_load;
  logic              pc_inc;
  logic              capture;
  logic              halt_word;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] last_add_q;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_val (br_target),
    .inc      (pc_inc),
    .pc       (pc)
  );

`ifdef FETCH_HALT_EN
  assign halt_word = is_halt_opcode(instr_out[HALT_MSB:HALT_LSB]);
  assign halted    = (state_q == ST_HALTED);
`else
  assign halt_word = 1'b0;
  assign halted    = 1'b0;
`endif

  // The memory port is used read-only.
  assign mem_en      = 1'b0;
  assign mem_data_in = '0;

  // The address follows pc only while issuing; otherwise it holds the last issued one.
  assign mem_add     = (state_q == ST_ISSUE) ? pc : last_add_q;
  assign instr_valid = (state_q == ST_PRESENT);

  // State register; reset wins over a simultaneous redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ISSUE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath controls; a redirect overrides every state.
  always_comb begin
    state_d = state_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    capture = 1'b0;
    if (br_taken) begin
      state_d = ST_ISSUE;
      pc_load = 1'b1;
    end else begin
      case (state_q)
        ST_ISSUE:   state_d = ST_CAPTURE;
        ST_CAPTURE: begin
          capture = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_PRESENT;
        end
        ST_PRESENT: begin
          if (instr_ready) begin
            state_d = halt_word ? ST_HALTED : ST_ISSUE;
          end
        end
        ST_HALTED:  state_d = ST_HALTED;
        default:    state_d = ST_ISSUE;
      endcase
    end
  end

  // Remember the address most recently driven during ISSUE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_add_q <= RESET_PC;
    end else if (state_q == ST_ISSUE) begin
      last_add_q <= pc;
    end
  end

  // Capture the returned word and the pc it came from.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_out <= '0;
      instr_pc  <= '0;
    end else if (capture) begin
      instr_out <= mem_data_out;
      instr_pc  <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memoria model, reset check, directed vector
// table, wrap / redirect-collision / HALT sequences and a randomized run
// against a transaction-level reference model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  mem_add;
  logic        mem_en;
  logic [13:0] mem_data_in;
  logic [13:0] mem_data_out;
  logic [13:0] instr_out;
  logic [4:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_taken;
  logic [4:0]  br_target;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_add      (mem_add),
    .mem_en       (mem_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .halted       (halted)
  );

  // ---------------- clock / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [13:0] mem [32];
  always @(posedge clk) mem_data_out <= mem[mem_add];

  initial begin
    #500000;
    $display("FAIL timeout reached before end of test");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // Abstract view: after a reset/redirect/accept, the word at m_pc is
  // presented two cycles later; m_pc then advances modulo 32.
  int          m_pc;
  int          m_wait;
  int          m_last;
  bit          m_valid;
  bit          m_halted;
  logic [13:0] m_exp_instr;
  int          m_exp_pc;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        s_valid;
  logic [4:0]  s_pc;
  logic [13:0] s_instr;
  logic        s_halted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_wait = 2; m_last = 0; m_valid = 1'b0; m_halted = 1'b0;
    m_exp_pc = 0; m_exp_instr = '0;
  endtask

  // Called just after a falling edge: compare, drive inputs, advance model.
  task automatic check_and_drive(input logic br, input logic [4:0] tgt, input logic rdy);
    int exp_add;
    s_valid = instr_valid; s_pc = instr_pc; s_instr = instr_out; s_halted = halted;
    if (!m_halted && !m_valid && m_wait == 2) begin
      exp_add = m_pc;
      m_last  = m_pc;
    end else begin
      exp_add = m_last;
    end
    chk("model_valid", 32'(instr_valid), 32'(m_valid));
    if (m_valid) begin
      chk("model_pc", 32'(instr_pc), 32'(m_exp_pc));
      chk("model_instr", 32'(instr_out), 32'(m_exp_instr));
    end
    chk("model_mem_add", 32'(mem_add), 32'(exp_add));
    chk("mem_en", 32'(mem_en), 32'd0);
    chk("mem_data_in", 32'(mem_data_in), 32'd0);
    chk("model_halted", 32'(halted), 32'(m_halted));
    br_taken = br; br_target = tgt; instr_ready = rdy;
    if (br) begin
      m_pc = int'(tgt); m_wait = 2; m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_wait = 0;
    end else if (m_valid) begin
      if (rdy) begin
        m_valid = 1'b0;
        if (HALT_EN && m_exp_instr[13:10] == 4'hF) m_halted = 1'b1;
        else m_wait = 2;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid     = 1'b1;
        m_exp_pc    = m_pc;
        m_exp_instr = mem[m_pc];
        m_pc        = (m_pc + 1) % 32;
      end
    end
  endtask

  task automatic step(input logic br, input logic [4:0] tgt, input logic rdy);
    @(negedge clk);
    check_and_drive(br, tgt, rdy);
  endtask

  // Reset for three edges with a redirect requested on the first one.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; br_taken = 1'b1; br_target = 5'd17; instr_ready = 1'b1;
    @(negedge clk);
    br_taken = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_mem_add", 32'(mem_add), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_instr_out", 32'(instr_out), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    rst_n = 1'b1;
    model_reset();
    check_and_drive(1'b0, 5'd0, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ready;
    logic        valid;
    logic [4:0]  pc;
    logic [13:0] instr;
    logic [4:0]  add;
  } vec_t;

  vec_t        tbl [22];
  logic [4:0]  seen [$];
  logic        cv [3];

  initial begin
    rst_n = 1'b0; br_taken = 1'b0; br_target = '0; instr_ready = 1'b0;
    for (int k = 0; k < 32; k++) mem[k] = 14'(k + 100);

    // sequential fetch, then 5 cycles of backpressure at pc 4
    tbl[0]  = '{1'b1, 1'b0, 5'd0, 14'd0,   5'd0};
    tbl[1]  = '{1'b1, 1'b1, 5'd0, 14'd100, 5'd0};
    tbl[2]  = '{1'b1, 1'b0, 5'd0, 14'd0,   5'd1};
    tbl[3]  = '{1'b1, 1'b0, 5'd0, 14'd0,   5'd1};
    tbl[4]  = '{1'b1, 1'b1, 5'd1, 14'd101, 5'd1};
    tbl[5]  = '{1'b1, 1'b0, 5'd0, 14'd0,   5'd2};
    tbl[6]  = '{1'b1, 1'b0, 5'd0, 14'd0,   5'd2};
    tbl[7]  = '{1'b1, 1'b1, 5'd2, 14'd102, 5'd2};
    tbl[8]  = '{1'b1, 1'b0, 5'd0, 14'd0,   5'd3};
    tbl[9]  = '{1'b1, 1'b0, 5'd0, 14'd0,   5'd3};
    tbl[10] = '{1'b1, 1'b1, 5'd3, 14'd103, 5'd3};
    tbl[11] = '{1'b1, 1'b0, 5'd0, 14'd0,   5'd4};
    tbl[12] = '{1'b1, 1'b0, 5'd0, 14'd0,   5'd4};
    tbl[13] = '{1'b0, 1'b1, 5'd4, 14'd104, 5'd4};
    tbl[14] = '{1'b0, 1'b1, 5'd4, 14'd104, 5'd4};
    tbl[15] = '{1'b0, 1'b1, 5'd4, 14'd104, 5'd4};
    tbl[16] = '{1'b0, 1'b1, 5'd4, 14'd104, 5'd4};
    tbl[17] = '{1'b0, 1'b1, 5'd4, 14'd104, 5'd4};
    tbl[18] = '{1'b1, 1'b1, 5'd4, 14'd104, 5'd4};
    tbl[19] = '{1'b1, 1'b0, 5'd0, 14'd0,   5'd5};
    tbl[20] = '{1'b1, 1'b0, 5'd0, 14'd0,   5'd5};
    tbl[21] = '{1'b0, 1'b1, 5'd5, 14'd105, 5'd5};

    do_reset();

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_mem_add", i), 32'(mem_add), 32'(tbl[i].add));
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_pc", i), 32'(instr_pc), 32'(tbl[i].pc));
        chk($sformatf("tbl%0d_instr", i), 32'(instr_out), 32'(tbl[i].instr));
      end
      check_and_drive(1'b0, 5'd0, tbl[i].ready);
    end

    // wrap: redirect to 30, ready high
    step(1'b1, 5'd30, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 5'd0, 1'b1);
      if (s_valid) seen.push_back(s_pc);
    end
    chk("wrap_count", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      chk("wrap_pc0", 32'(seen[0]), 32'd30);
      chk("wrap_pc1", 32'(seen[1]), 32'd31);
      chk("wrap_pc2", 32'(seen[2]), 32'd0);
      chk("wrap_pc3", 32'(seen[3]), 32'd1);
    end

    // redirect collides with acceptance of the word at pc 2
    step(1'b1, 5'd2, 1'b0);
    step(1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd9, 1'b1);
    chk("coll_pc2_valid", 32'(s_valid), 32'd1);
    chk("coll_pc2_pc", 32'(s_pc), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 1'b0);
      cv[i] = s_valid;
    end
    chk("coll_v1", 32'(cv[0]), 32'd0);
    chk("coll_v2", 32'(cv[1]), 32'd0);
    chk("coll_v3", 32'(cv[2]), 32'd1);
    chk("coll_pc9", 32'(s_pc), 32'd9);
    chk("coll_instr", 32'(s_instr), 32'd109);

    // HALT word at address 3
    mem[3] = 14'h3C00;
    step(1'b1, 5'd3, 1'b0);
    step(1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 1'b1);
    chk("halt_word_valid", 32'(s_valid), 32'd1);
    chk("halt_word_instr", 32'(s_instr), 32'h3C00);
    step(1'b0, 5'd0, 1'b1);
`ifdef FETCH_HALT_EN
    chk("halt_set", 32'(s_halted), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'd0, 1'b1);
      chk("halt_hold", 32'(s_halted), 32'd1);
      chk("halt_mem_add", 32'(mem_add), 32'd3);
      chk("halt_no_valid", 32'(s_valid), 32'd0);
    end
    step(1'b1, 5'd0, 1'b1);
    step(1'b0, 5'd0, 1'b1);
    chk("halt_clear", 32'(s_halted), 32'd0);
    step(1'b0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 1'b1);
    chk("halt_restart_valid", 32'(s_valid), 32'd1);
    chk("halt_restart_pc", 32'(s_pc), 32'd0);
`else
    chk("nohalt_halted", 32'(s_halted), 32'd0);
    step(1'b0, 5'd0, 1'b1);
    step(1'b0, 5'd0, 1'b1);
    chk("nohalt_next_valid", 32'(s_valid), 32'd1);
    chk("nohalt_next_pc", 32'(s_pc), 32'd4);
    chk("nohalt_next_instr", 32'(s_instr), 32'd104);
`endif
    step(1'b0, 5'd0, 1'b0);

    // randomized run against the model; memory rewritten while reset is pending
    for (int k = 0; k < 32; k++) mem[k] = 14'($urandom_range(0, 16383));
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 9) == 0), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    // reset in the middle of activity, then a short run
    do_reset();
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 5'd0, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
